// File: rtl/dmem_access_unit.sv
// Data-memory access unit: one load/store at a time against a word-wide
// memory with a single write enable. Sub-word stores are done as
// read-modify-write; misaligned or illegal requests respond with an error
// and leave memory untouched.
module dmem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR,
    RESP
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_we;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_error;

  logic                  w_misaligned;
  logic [ADDR_WIDTH-1:0] w_aligned_addr;
  logic [4:0]            w_shift;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [DATA_WIDTH-1:0] w_load_ext;
  logic [DATA_WIDTH-1:0] w_mask_base;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_merged;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;

  // Alignment check on the incoming request (only acted on in IDLE)
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = req_addr[0];
      2'd2:    w_misaligned = (req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

  // Half accesses are 2-byte aligned, so the byte-offset shift also selects the half lane
  assign w_aligned_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_shift        = {r_addr[1:0], 3'b000};
  assign w_lane         = mem_rdata >> w_shift;

  // Lane extraction with sign or zero extension for loads
  always_comb begin
    w_load_ext = w_lane;
    case (r_size)
      2'd0: w_load_ext = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]}
                                    : {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
      2'd1: w_load_ext = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]}
                                    : {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  // Lane mask for merging sub-word store data into the fetched word
  always_comb begin
    w_mask_base = '1;
    case (r_size)
      2'd0:    w_mask_base = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
      2'd1:    w_mask_base = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
      default: w_mask_base = '1;
    endcase
  end

  assign w_mask   = w_mask_base << w_shift;
  assign w_merged = (mem_rdata & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  // Control FSM with registered memory and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            if (w_misaligned) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= RESP;
            end else if (req_write && (req_size == 2'd2)) begin
              r_mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              r_mem_wdata <= req_wdata;
              r_mem_we    <= 1'b1;
              r_state     <= WR;
            end else begin
              r_state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          r_mem_addr <= w_aligned_addr;
          r_mem_we   <= 1'b0;
          r_state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (r_write) begin
            r_mem_wdata <= w_merged;
            r_mem_we    <= 1'b1;
            r_state     <= WR;
          end else begin
            r_resp_rdata <= w_load_ext;
            r_resp_error <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        WR: begin
          r_mem_we     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_error <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= RESP;
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_error <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a small behavioural word memory.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  int checks = 0;
  int errors = 0;

  int          o_lat;
  logic [31:0] o_rdata;
  logic        o_err;
  int          o_we_n;
  int          o_we_cyc;
  logic [31:0] o_we_data;
  int          rv_seen;
  int          we_seen;

  dmem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: read data follows the registered address, writes commit at the edge
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issue one request; measure cycles from accept edge to resp_valid and watch mem_we
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'h5A5A_5A5A;
    o_lat = 1; o_we_n = 0; o_we_cyc = 0; o_we_data = '0;
    if (mem_we) begin o_we_n++; o_we_cyc = 1; o_we_data = mem_wdata; end
    while (!resp_valid && o_lat < 12) begin
      @(negedge clk);
      o_lat++;
      if (mem_we) begin o_we_n++; o_we_cyc = o_lat; o_we_data = mem_wdata; end
    end
    if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
    o_rdata = resp_rdata;
    o_err   = resp_error;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    for (int unsigned i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr",   mem_addr, 32'd0);
    check("rst_mem_wdata",  mem_wdata, 32'd0);

    preload(6'd4,  32'h8899AABB);
    preload(6'd8,  32'h11223344);
    preload(6'd16, 32'hCAFEF00D);
    rst = 1'b0;
    @(negedge clk);

    // Loads from 0x10 = 0x8899AABB
    do_req(1'b0, 2'd0, 1'b0, 32'h11, '0);
    check("lb_0x11_lat",   o_lat, 3);
    check("lb_0x11_data",  o_rdata, 32'hFFFFFFAA);
    check("lb_0x11_err",   {31'd0, o_err}, 32'd0);
    check("lb_0x11_we",    o_we_n, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, '0);
    check("lhu_0x12_data", o_rdata, 32'h00008899);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, '0);
    check("lw_0x10_data",  o_rdata, 32'h8899AABB);
    check("lw_0x10_lat",   o_lat, 3);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, '0);
    check("lh_0x12_data",  o_rdata, 32'hFFFF8899);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, '0);
    check("lbu_0x13_data", o_rdata, 32'h00000088);
    do_req(1'b0, 2'd0, 1'b0, 32'h10, '0);
    check("lb_0x10_data",  o_rdata, 32'hFFFFFFBB);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, '0);
    check("lh_0x10_data",  o_rdata, 32'hFFFFAABB);

    // Sub-word stores into 0x20 = 0x11223344
    do_req(1'b1, 2'd0, 1'b0, 32'h23, 32'h000000EE);
    check("sb_0x23_lat",    o_lat, 4);
    check("sb_0x23_we_n",   o_we_n, 1);
    check("sb_0x23_we_cyc", o_we_cyc, 3);
    check("sb_0x23_wdata",  o_we_data, 32'hEE223344);
    check("sb_0x23_rdata",  o_rdata, 32'd0);
    check("sb_0x23_err",    {31'd0, o_err}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, '0);
    check("lw_0x20_after_sb", o_rdata, 32'hEE223344);
    do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'hFFFF5678);
    check("sh_0x20_lat",    o_lat, 4);
    check("sh_0x20_wdata",  o_we_data, 32'hEE225678);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, '0);
    check("lw_0x20_after_sh", o_rdata, 32'hEE225678);
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF00);
    check("sb_0x21_wdata",  o_we_data, 32'hEE220078);

    // Word store then immediate word load
    do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'hDEADBEEF);
    check("sw_0x30_we_cyc", o_we_cyc, 1);
    check("sw_0x30_we_n",   o_we_n, 1);
    check("sw_0x30_lat",    o_lat, 2);
    check("sw_0x30_wdata",  o_we_data, 32'hDEADBEEF);
    check("sw_0x30_rdata",  o_rdata, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h30, '0);
    check("lw_0x30_data",   o_rdata, 32'hDEADBEEF);
    check("mem_0x30_model", mem[12], 32'hDEADBEEF);

    // Misaligned and illegal requests
    do_req(1'b0, 2'd2, 1'b0, 32'h32, '0);
    check("mis_lw_lat",   o_lat, 1);
    check("mis_lw_err",   {31'd0, o_err}, 32'd1);
    check("mis_lw_rdata", o_rdata, 32'd0);
    check("mis_lw_we",    o_we_n, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h05, '0);
    check("mis_lh_lat",   o_lat, 1);
    check("mis_lh_err",   {31'd0, o_err}, 32'd1);
    check("mis_lh_rdata", o_rdata, 32'd0);
    do_req(1'b0, 2'd3, 1'b0, 32'h40, '0);
    check("ill_sz3_lat",  o_lat, 1);
    check("ill_sz3_err",  {31'd0, o_err}, 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h31, 32'h12345678);
    check("mis_sw_err",   {31'd0, o_err}, 32'd1);
    check("mis_sw_we",    o_we_n, 0);
    check("mis_mem_addr_held", mem_addr, 32'h30);
    check("mis_mem_0x30", mem[12], 32'hDEADBEEF);

    // Reset during RD_WAIT of a byte store to 0x40
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h00000077;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0; we_seen = 0;
    if (resp_valid) rv_seen++;
    if (mem_we) we_seen++;
    @(negedge clk);
    check("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (resp_valid) rv_seen++;
      if (mem_we) we_seen++;
      @(negedge clk);
    end
    check("rstmid_no_resp", rv_seen, 0);
    check("rstmid_no_we",   we_seen, 0);
    check("rstmid_mem",     mem[16], 32'hCAFEF00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, '0);
    check("rstmid_reload",  o_rdata, 32'hCAFEF00D);
    check("rstmid_reload_lat", o_lat, 3);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
